// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator.
// Scans an H_TOTAL x V_TOTAL frame and emits the pixel coordinates, syncs,
// data enable and line/frame strobes. Every output is registered and shows
// the decode of the counter value before it advanced, so all outputs stay
// mutually aligned with one enabled edge of latency.
module video_timing_gen #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_de,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_line_start,
  output logic        o_frame_start
);

  localparam logic [15:0] H_LAST     = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_LAST     = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] H_ACT_END  = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT_END  = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START   = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END     = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_START   = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END     = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic [15:0] h_cnt;
  logic [15:0] v_cnt;

  logic h_last;
  logic v_last;
  logic h_in_sync;
  logic v_in_sync;
  logic in_active;

  // Region decode of the current (pre-advance) counter values.
  always_comb begin
    h_last    = (h_cnt == H_LAST);
    v_last    = (v_cnt == V_LAST);
    h_in_sync = (h_cnt >= HS_START) && (h_cnt < HS_END);
    v_in_sync = (v_cnt >= VS_START) && (v_cnt < VS_END);
    in_active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  end

  // Raster counters: advance one pixel per enabled edge, wrap at line/frame end.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (i_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? 16'd0 : v_cnt + 16'd1;
      end else begin
        h_cnt <= h_cnt + 16'd1;
      end
    end
  end

  // Output register: capture the decode on enabled edges; levels hold and
  // strobes drop when disabled so each strobe lasts a single clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_x           <= '0;
      o_y           <= '0;
      o_de          <= 1'b0;
      o_h_sync      <= ~SYNC_POL;
      o_v_sync      <= ~SYNC_POL;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else if (i_en) begin
      o_x           <= h_cnt;
      o_y           <= v_cnt;
      o_de          <= in_active;
      o_h_sync      <= h_in_sync ? SYNC_POL : ~SYNC_POL;
      o_v_sync      <= v_in_sync ? SYNC_POL : ~SYNC_POL;
      o_line_start  <= (h_cnt == 16'd0);
      o_frame_start <= (h_cnt == 16'd0) && (v_cnt == 16'd0);
    end else begin
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end
  end

endmodule
